// File: rtl/key_filter_multi_pkg.sv
// Shared definitions for the multi-key debounce filter.
// Holds the one-hot channel FSM states, default timing constants and a
// counter-width helper.
package key_filter_multi_pkg;

  // One-hot channel FSM states
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_FILTER0 = 5'b00010,
    ST_DOWN    = 5'b00100,
    ST_HOLD    = 5'b01000,
    ST_FILTER1 = 5'b10000
  } state_e;

  // Defaults for a 50 MHz clock
  localparam int unsigned DEF_N_KEYS        = 4;
  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

  // Bits needed to count 0..n-1 (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/key_filter_chan.sv
// Single key channel: synchroniser, debounce FSM, long-press and auto-repeat.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   key_in         raw asynchronous key level
//   repeat_en      enables long-press / repeat events for this key
//   key_state      debounced level (1 = released, 0 = pressed)
//   press_pulse    one-cycle pulse on debounced press
//   release_pulse  one-cycle pulse on debounced release
//   long_pulse     one-cycle pulse after LONG_CYCLES of hold
//   repeat_pulse   one-cycle pulse every REPEAT_CYCLES after long_pulse
//   event_c        high in the cycle before a press or release pulse
module key_filter_chan
  import key_filter_multi_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic event_c
);

  localparam int unsigned DW  = cnt_width(DB_CYCLES);
  localparam int unsigned HW  = cnt_width(LONG_CYCLES);
  localparam int unsigned RW  = cnt_width(REPEAT_CYCLES);
  localparam logic        REL = (ACTIVE_LOW != 0);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          act;
  state_e        state;
  logic          from_hold;
  logic [DW-1:0] cnt;
  logic [HW-1:0] hold;
  logic [RW-1:0] rep;
  logic          cnt_done;
  logic          long_due;
  logic          rep_due;
  logic [HW-1:0] hold_nxt;
  logic [RW-1:0] rep_nxt;

  // Two-flop synchroniser plus edge-detect stage, parked at the released level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= REL;
      sync2 <= REL;
      level <= REL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      level <= sync2;
    end
  end

  // The FSM reacts to the level disagreeing with its state, so an edge that
  // coincides with a completing filter is picked up on the following cycle.
  assign act      = (level != REL);
  assign cnt_done = (cnt == DW'(DB_CYCLES - 1));
  assign long_due = repeat_en && (hold >= HW'(LONG_CYCLES - 1));
  assign rep_due  = (rep == RW'(REPEAT_CYCLES - 1));
  assign hold_nxt = (&hold) ? hold : hold + HW'(1);
  assign rep_nxt  = rep_due ? '0 : rep + RW'(1);
  assign event_c  = ((state == ST_FILTER0) || (state == ST_FILTER1)) && cnt_done;

  // Debounce / hold FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      from_hold     <= 1'b0;
      cnt           <= '0;
      hold          <= '0;
      rep           <= '0;
      key_state     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          key_state <= 1'b1;
          if (act) begin
            state <= ST_FILTER0;
            cnt   <= '0;
          end
        end
        ST_FILTER0: begin
          if (cnt_done) begin
            state       <= ST_DOWN;
            press_pulse <= 1'b1;
            key_state   <= 1'b0;
            hold        <= '0;
            rep         <= '0;
            from_hold   <= 1'b0;
          end else if (!act) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        ST_DOWN: begin
          hold <= hold_nxt;
          if (long_due) begin
            long_pulse <= 1'b1;
            from_hold  <= 1'b1;
            rep        <= '0;
          end
          if (!act) begin
            state <= ST_FILTER1;
            cnt   <= '0;
          end else if (long_due) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          hold         <= hold_nxt;
          rep          <= rep_nxt;
          repeat_pulse <= rep_due;
          if (!act) begin
            state <= ST_FILTER1;
            cnt   <= '0;
          end
        end
        ST_FILTER1: begin
          hold <= hold_nxt;
          // Keep the repeat cadence running but silent while filtering
          if (from_hold) rep <= rep_nxt;
          if (cnt_done) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
            key_state     <= 1'b1;
            from_hold     <= 1'b0;
          end else if (act) begin
            state <= from_hold ? ST_HOLD : ST_DOWN;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          key_state <= 1'b1;
          from_hold <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_filter_multi.sv
// Multi-key debounce filter: N_KEYS independent channels plus a shared flag.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   key_in         raw key levels
//   repeat_en      per-key long-press / repeat enable
//   key_state      debounced levels (1 = released)
//   press_pulse, release_pulse, long_pulse, repeat_pulse   per-key events
//   key_flag       OR of all press and release pulses, same cycle
module key_filter_multi
  import key_filter_multi_pkg::*;
#(
  parameter int unsigned N_KEYS        = DEF_N_KEYS,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_in,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              key_flag
);

  logic [N_KEYS-1:0] event_c;

  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_chan
    key_filter_chan #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .key_in       (key_in[i]),
      .repeat_en    (repeat_en[i]),
      .key_state    (key_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .event_c      (event_c[i])
    );
  end

  // Registered from the channels' look-ahead so it lines up with the pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_flag <= 1'b0;
    else          key_flag <= |event_c;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Self-checking bench for key_filter_multi (2 keys, DB=8, LONG=40, REPEAT=10).
module tb_key_filter_multi;

  localparam int DB = 8;
  localparam int LG = 40;
  localparam int RP = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] key_in = 2'b11;
  logic [1:0] repeat_en = 2'b00;
  logic [1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic       key_flag;

  always #5 clk = ~clk;

  key_filter_multi #(
    .N_KEYS(2), .DB_CYCLES(DB), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .repeat_en(repeat_en),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .key_flag(key_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tcyc     = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int diff_at(input int q[$], input int i, input int base);
    return (q.size() > i) ? q[i] - base : -9999;
  endfunction

  initial forever begin
    @(posedge clk);
    tcyc++;
  end

  // Reference model: a key level seen 3 samples late; DB consecutive opposite
  // samples flip the debounced state; long/repeat timed from the flip edge.
  logic [1:0] hist[$];
  bit         deb[2];
  bit         longd[2];
  int         run[2], pt[2], lt[2];
  int         e_m = 0;
  logic [1:0] x_state = 2'b11, x_press = 2'b00, x_rel = 2'b00, x_long = 2'b00, x_rep = 2'b00;
  logic       x_flag = 1'b0;
  logic [1:0] m_s;
  bit         m_v;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      hist.delete();
      e_m = 0;
      x_state = 2'b11; x_press = 2'b00; x_rel = 2'b00; x_long = 2'b00; x_rep = 2'b00; x_flag = 1'b0;
      for (int k = 0; k < 2; k++) begin
        deb[k] = 0; longd[k] = 0; run[k] = 0; pt[k] = 0; lt[k] = 0;
      end
    end else begin
      hist.push_back(key_in);
      if (hist.size() > 4) void'(hist.pop_front());
      x_press = 2'b00; x_rel = 2'b00; x_long = 2'b00; x_rep = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_v = 0;
        if (hist.size() == 4) begin
          m_s = hist[0];
          m_v = (m_s[k] == 1'b0);
        end
        if (run[k] == DB) begin
          deb[k] = !deb[k];
          run[k] = 0;
          if (deb[k]) begin
            x_press[k] = 1'b1; pt[k] = e_m; longd[k] = 0;
          end else begin
            x_rel[k] = 1'b1;
          end
        end else begin
          if (deb[k] && run[k] == 0) begin
            if (!longd[k] && repeat_en[k] && (e_m - pt[k]) >= LG) begin
              x_long[k] = 1'b1; longd[k] = 1; lt[k] = e_m;
            end else if (longd[k] && ((e_m - lt[k]) % RP) == 0) begin
              x_rep[k] = 1'b1;
            end
          end
          if (m_v != deb[k]) run[k]++;
          else run[k] = 0;
        end
      end
      x_state = {!deb[1], !deb[0]};
      x_flag  = |{x_press, x_rel};
      e_m++;
    end
  end

  // Per-cycle compare and key0 event log
  int p0[$], r0[$], l0[$], q0[$];
  int sim_hits = 0;

  initial forever begin
    @(negedge clk);
    n_checks++;
    if ({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag} ===
        {x_state, x_press, x_rel, x_long, x_rep, x_flag}) begin
      n_pass++;
    end else begin
      $display("FAIL outputs cyc=%0d: got st=%b pr=%b rl=%b lg=%b rp=%b fl=%b, expected st=%b pr=%b rl=%b lg=%b rp=%b fl=%b",
               tcyc, key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag,
               x_state, x_press, x_rel, x_long, x_rep, x_flag);
    end
    if (press_pulse[0])   p0.push_back(tcyc);
    if (release_pulse[0]) r0.push_back(tcyc);
    if (long_pulse[0])    l0.push_back(tcyc);
    if (repeat_pulse[0])  q0.push_back(tcyc);
    if (press_pulse == 2'b11 && key_flag) sim_hits++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    p0.delete(); r0.delete(); l0.delete(); q0.delete();
  endtask

  int d;
  int dwell[2];

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("reset_outputs", int'({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag}),
          int'({2'b11, 9'b0}));

    // Clean press and release
    clear_log();
    d = tcyc; key_in[0] = 1'b0;
    tick(20);
    check("clean_press_count", p0.size(), 1);
    check("clean_press_latency", diff_at(p0, 0, d + 1), 11);
    check("clean_key_state", int'(key_state), 2);
    d = tcyc; key_in[0] = 1'b1;
    tick(20);
    check("clean_release_count", r0.size(), 1);
    check("clean_release_latency", diff_at(r0, 0, d + 1), 11);

    // Bounce before settling
    clear_log();
    key_in[0] = 1'b0; tick(5);
    key_in[0] = 1'b1; tick(2);
    d = tcyc; key_in[0] = 1'b0;
    tick(20);
    check("bounce_press_count", p0.size(), 1);
    check("bounce_press_latency", diff_at(p0, 0, d + 1), 11);
    check("bounce_no_release", r0.size(), 0);
    key_in[0] = 1'b1; tick(20);

    // Long press with repeats
    clear_log();
    repeat_en = 2'b01;
    d = tcyc; key_in[0] = 1'b0;
    tick(80);
    key_in[0] = 1'b1;
    tick(20);
    check("long_after_press", diff_at(l0, 0, diff_at(p0, 0, 0)), 40);
    check("repeat1_after_long", diff_at(q0, 0, diff_at(l0, 0, 0)), 10);
    check("repeat2_after_long", diff_at(q0, 1, diff_at(l0, 0, 0)), 20);
    check("long_repeat_count", q0.size(), 3);
    check("long_release_count", r0.size(), 1);
    check("long_key_state", int'(key_state), 3);

    // Release glitch while in HOLD
    clear_log();
    d = tcyc; key_in[0] = 1'b0;
    tick(73);
    key_in[0] = 1'b1; tick(3);
    key_in[0] = 1'b0; tick(30);
    check("glitch_no_release", r0.size(), 0);
    check("glitch_repeat_count", q0.size(), 5);
    check("glitch_repeat_cadence", diff_at(q0, 2, diff_at(l0, 0, 0)), 30);
    check("glitch_repeat_last", diff_at(q0, 4, diff_at(l0, 0, 0)), 50);
    key_in[0] = 1'b1; tick(20);
    check("glitch_final_release", r0.size(), 1);

    // Simultaneous press
    clear_log();
    repeat_en = 2'b00;
    key_in = 2'b00; tick(20);
    check("simultaneous_press", sim_hits, 1);
    key_in = 2'b11; tick(20);

    // Reset while in HOLD, key kept pressed
    clear_log();
    repeat_en = 2'b01;
    key_in[0] = 1'b0; tick(60);
    check("pre_reset_long", l0.size(), 1);
    clear_log();
    reset_n = 1'b0;
    #1;
    check("reset_async", int'({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, key_flag}),
          int'({2'b11, 9'b0}));
    tick(2);
    d = tcyc; reset_n = 1'b1;
    tick(20);
    check("reset_repress_latency", diff_at(p0, 0, d + 1), 11);
    check("reset_no_release", r0.size(), 0);
    key_in[0] = 1'b1; tick(20);

    // Randomised key activity against the model
    dwell[0] = 3; dwell[1] = 7;
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 0) repeat_en = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        dwell[k]--;
        if (dwell[k] <= 0) begin
          key_in[k] = ~key_in[k];
          dwell[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9))
                                                 : int'($urandom_range(9, 90));
        end
      end
      tick(1);
    end
    key_in = 2'b11;
    tick(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
